instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 161 ++++++++++++++++
 tb/tb_instr_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Single-stage instruction fetch unit. It holds an 8-bit word-address PC,
// presents it combinationally to the instruction memory, and registers the
// returned word into a fetch register (instr_out / pc_out / valid_out) one
// cycle later. The fetch sequence ends after the word at LAST_ADDR has been
// fetched (state DONE). A taken branch redirects the PC and also restarts
// fetching from DONE.
//
// Update priority per clock edge: rst > branch_taken > flush > stall > fetch.
//
// Parameters
//   RESET_PC      word address loaded into the PC on reset
//   LAST_ADDR     final program word; a normal fetch of it enters DONE
//
// Ports
//   clk            in   1   sole clock, rising edge
//   rst            in   1   synchronous active-high reset
//   stall          in   1   hold PC and fetch register
//   flush          in   1   load a bubble into the fetch register
//   branch_taken   in   1   redirect PC to branch_target
//   branch_target  in   8   redirect word address
//   imem_addr      out  8   word address to instruction memory (= PC)
//   imem_rd        in   32  instruction word for imem_addr (combinational)
//   instr_out      out  32  registered fetched instruction
//   pc_out         out  8   registered address of instr_out
//   valid_out      out  1   fetch register holds a real instruction
//   done           out  1   high while in DONE
//   fetch_count    out  16  accepted fetches, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [7:0] RESET_PC  = 8'd0,
  parameter logic [7:0] LAST_ADDR = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr_out,
  output logic [7:0]  pc_out,
  output logic        valid_out,
  output logic        done,
  output logic [15:0] fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [15:0] count_q, count_d;

  // 8-bit add wraps 255 -> 0 naturally.
  logic [7:0]  pc_inc;
  assign pc_inc = pc_q + 8'd1;

  // Next-state and next-output computation for every non-reset edge.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    count_d  = count_q;

    if (branch_taken) begin
      // Branch overrides stall/flush and also resumes from DONE.
      state_d  = ST_RUN;
      pc_d     = branch_target;
      instr_d  = 32'h0000_0000;
      pc_out_d = 8'd0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (flush) begin
            instr_d  = 32'h0000_0000;
            pc_out_d = 8'd0;
            valid_d  = 1'b0;
            // A flush alone never ends the program; PC still obeys stall.
            if (!stall) begin
              pc_d = pc_inc;
            end else begin
              pc_d = pc_q;
            end
          end else if (stall) begin
            pc_d     = pc_q;
            instr_d  = instr_q;
            pc_out_d = pc_out_q;
            valid_d  = valid_q;
          end else begin
            instr_d  = imem_rd;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_inc;
            if (count_q == 16'hFFFF) begin
              count_d = count_q;
            end else begin
              count_d = count_q + 16'd1;
            end
            if (pc_q == LAST_ADDR) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_DONE: begin
          // Idle: only the valid flag drops; stall/flush are irrelevant here.
          valid_d = 1'b0;
        end
        default: begin
          state_d = ST_RUN;
          valid_d = 1'b0;
        end
      endcase
    end

    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0000_0000;
      pc_out_q <= 8'd0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign valid_out   = valid_q;
  assign done        = done_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Three instances with different RESET_PC / LAST_ADDR share clock and control
// inputs; each reads its own view of a shared 256-word instruction memory.
// A per-instance reference model tracks the expected architectural state and
// every output is compared after every edge, alongside hand-derived constant
// checks for the directed program scenarios. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_taken;
  logic [7:0]  branch_target;

  logic [31:0] mem [256];

  logic [7:0]  addr_w  [3];
  logic [31:0] rd_w    [3];
  logic [31:0] instr_w [3];
  logic [7:0]  pco_w   [3];
  logic        valid_w [3];
  logic        done_w  [3];
  logic [15:0] cnt_w   [3];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state per instance
  int m_pc    [3];
  int m_instr [3];
  int m_pco   [3];
  int m_valid [3];
  int m_done  [3];
  int m_cnt   [3];
  int cfg_rpc  [3] = '{0, 254, 0};
  int cfg_last [3] = '{4, 255, 0};

  always #5 clk = ~clk;

  assign rd_w[0] = mem[addr_w[0]];
  assign rd_w[1] = mem[addr_w[1]];
  assign rd_w[2] = mem[addr_w[2]];

  instr_fetch #(.RESET_PC(8'd0), .LAST_ADDR(8'd4)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(addr_w[0]), .imem_rd(rd_w[0]), .instr_out(instr_w[0]),
    .pc_out(pco_w[0]), .valid_out(valid_w[0]), .done(done_w[0]),
    .fetch_count(cnt_w[0])
  );

  instr_fetch #(.RESET_PC(8'd254), .LAST_ADDR(8'd255)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(addr_w[1]), .imem_rd(rd_w[1]), .instr_out(instr_w[1]),
    .pc_out(pco_w[1]), .valid_out(valid_w[1]), .done(done_w[1]),
    .fetch_count(cnt_w[1])
  );

  instr_fetch #(.RESET_PC(8'd0), .LAST_ADDR(8'd0)) dut_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(addr_w[2]), .imem_rd(rd_w[2]), .instr_out(instr_w[2]),
    .pc_out(pco_w[2]), .valid_out(valid_w[2]), .done(done_w[2]),
    .fetch_count(cnt_w[2])
  );

  // Single comparison point: counts and reports.
  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural rules applied to one instance for the inputs present at an edge.
  task automatic model_step(input int k);
    if (rst) begin
      m_pc[k] = cfg_rpc[k]; m_instr[k] = 0; m_pco[k] = 0;
      m_valid[k] = 0; m_cnt[k] = 0; m_done[k] = 0;
    end else if (branch_taken) begin
      m_pc[k] = branch_target; m_instr[k] = 0; m_pco[k] = 0;
      m_valid[k] = 0; m_done[k] = 0;
    end else if (m_done[k] != 0) begin
      m_valid[k] = 0;
    end else if (flush) begin
      m_instr[k] = 0; m_pco[k] = 0; m_valid[k] = 0;
      if (!stall) m_pc[k] = (m_pc[k] + 1) % 256;
    end else if (!stall) begin
      m_instr[k] = mem[m_pc[k]];
      m_pco[k]   = m_pc[k];
      m_valid[k] = 1;
      m_cnt[k]   = (m_cnt[k] >= 65535) ? 65535 : m_cnt[k] + 1;
      if (m_pc[k] == cfg_last[k]) m_done[k] = 1;
      m_pc[k]    = (m_pc[k] + 1) % 256;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk_eq($sformatf("m%0d.imem_addr", k), 32'(addr_w[k]),  32'(m_pc[k]));
      chk_eq($sformatf("m%0d.instr_out", k), instr_w[k],      32'(m_instr[k]));
      chk_eq($sformatf("m%0d.pc_out", k),    32'(pco_w[k]),   32'(m_pco[k]));
      chk_eq($sformatf("m%0d.valid_out", k), 32'(valid_w[k]), 32'(m_valid[k]));
      chk_eq($sformatf("m%0d.done", k),      32'(done_w[k]),  32'(m_done[k]));
      chk_eq($sformatf("m%0d.fetch_count", k), 32'(cnt_w[k]), 32'(m_cnt[k]));
    end
  endtask

  // One clock: model steps with the inputs seen at the edge, outputs checked
  // after settling, and the next inputs are applied at the falling edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = 8'd0;
  endtask

  logic [31:0] prog [5];

  initial begin
    prog[0] = 32'h20010003; prog[1] = 32'h20020009; prog[2] = 32'h00221020;
    prog[3] = 32'h00221824; prog[4] = 32'h00222025;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    for (int i = 0; i < 5; i++) mem[i] = prog[i];
    for (int k = 0; k < 3; k++) begin
      m_pc[k] = 0; m_instr[k] = 0; m_pco[k] = 0;
      m_valid[k] = 0; m_done[k] = 0; m_cnt[k] = 0;
    end
    idle_inputs();
    rst = 1'b1;

    // Reset state
    tick(); tick();
    chk_eq("rst.valid", 32'(valid_w[0]), 32'd0);
    chk_eq("rst.pc_out", 32'(pco_w[0]), 32'd0);
    chk_eq("rst.instr", instr_w[0], 32'd0);
    chk_eq("rst.count", 32'(cnt_w[0]), 32'd0);
    chk_eq("rst.done", 32'(done_w[0]), 32'd0);
    chk_eq("rst.addr_a", 32'(addr_w[0]), 32'd0);
    chk_eq("rst.addr_b", 32'(addr_w[1]), 32'd254);

    // Straight-line program 0..4, then DONE
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_eq("prog.pc_out", 32'(pco_w[0]), 32'(i));
      chk_eq("prog.instr", instr_w[0], prog[i]);
      chk_eq("prog.valid", 32'(valid_w[0]), 32'd1);
      if (i == 0) chk_eq("b.pc_out254", 32'(pco_w[1]), 32'd254);
      if (i == 1) begin
        chk_eq("b.pc_out255", 32'(pco_w[1]), 32'd255);
        chk_eq("b.done", 32'(done_w[1]), 32'd1);
      end
    end
    chk_eq("prog.done_at4", 32'(done_w[0]), 32'd1);
    chk_eq("prog.count5", 32'(cnt_w[0]), 32'd5);
    chk_eq("prog.addr5", 32'(addr_w[0]), 32'd5);
    tick();
    chk_eq("done.valid", 32'(valid_w[0]), 32'd0);
    chk_eq("done.done", 32'(done_w[0]), 32'd1);
    chk_eq("done.addr_hold", 32'(addr_w[0]), 32'd5);
    chk_eq("done.count_hold", 32'(cnt_w[0]), 32'd5);
    stall = 1'b1; flush = 1'b1;
    tick();
    chk_eq("done.flush_pc_hold", 32'(pco_w[0]), 32'd4);
    chk_eq("done.flush_instr_hold", instr_w[0], prog[4]);
    stall = 1'b0; flush = 1'b0;

    // Branch to 0 from DONE replays the program
    branch_taken = 1'b1; branch_target = 8'd0;
    tick();
    chk_eq("replay.done_fall", 32'(done_w[0]), 32'd0);
    chk_eq("replay.valid0", 32'(valid_w[0]), 32'd0);
    branch_taken = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_eq("replay.count10", 32'(cnt_w[0]), 32'd10);
    chk_eq("replay.done", 32'(done_w[0]), 32'd1);

    // Stall held three cycles at PC = 2
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("stall.addr", 32'(addr_w[0]), 32'd2);
      chk_eq("stall.instr", instr_w[0], 32'h20020009);
      chk_eq("stall.pc_out", 32'(pco_w[0]), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk_eq("stall.release_pc", 32'(pco_w[0]), 32'd2);

    // Branch with stall and flush at PC = 3
    branch_taken = 1'b1; branch_target = 8'd1; stall = 1'b1; flush = 1'b1;
    tick();
    chk_eq("br.valid", 32'(valid_w[0]), 32'd0);
    chk_eq("br.addr", 32'(addr_w[0]), 32'd1);
    idle_inputs();
    tick();
    chk_eq("br.pc_out", 32'(pco_w[0]), 32'd1);
    chk_eq("br.instr", instr_w[0], 32'h20020009);

    // Flush without stall: bubble, PC advances, count unchanged
    flush = 1'b1;
    tick();
    chk_eq("flush.valid", 32'(valid_w[0]), 32'd0);
    chk_eq("flush.addr", 32'(addr_w[0]), 32'd3);
    flush = 1'b0;

    // Reset mid-program with stall high
    rst = 1'b1; stall = 1'b1;
    tick();
    chk_eq("mrst.valid", 32'(valid_w[0]), 32'd0);
    chk_eq("mrst.instr", instr_w[0], 32'd0);
    chk_eq("mrst.pc_out", 32'(pco_w[0]), 32'd0);
    chk_eq("mrst.count", 32'(cnt_w[0]), 32'd0);
    chk_eq("mrst.addr", 32'(addr_w[0]), 32'd0);
    idle_inputs();

    // PC wrap with LAST_ADDR = 0 (instance c)
    branch_taken = 1'b1; branch_target = 8'd255;
    tick();
    branch_taken = 1'b0;
    tick();
    chk_eq("wrap.pc_out255", 32'(pco_w[2]), 32'd255);
    chk_eq("wrap.addr0", 32'(addr_w[2]), 32'd0);
    chk_eq("wrap.not_done", 32'(done_w[2]), 32'd0);
    tick();
    chk_eq("wrap.pc_out0", 32'(pco_w[2]), 32'd0);
    chk_eq("wrap.done", 32'(done_w[2]), 32'd1);

    // Randomized phase
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 99) < 2);
      branch_taken  = ($urandom_range(0, 99) < 8);
      flush         = ($urandom_range(0, 99) < 10);
      stall         = ($urandom_range(0, 99) < 20);
      branch_target = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5))
                                                  : 8'($urandom_range(0, 255));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
